// File: rtl/exp_arbiter.sv
// exp_arbiter: round-robin arbiter that shares one exponential unit among
// N_REQ requesters. One job is outstanding at a time. A job that times out
// returns rsp_err=1, and the late result from the unit is then flushed.
module exp_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_x,
  output logic [N_REQ-1:0]       req_ack,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_y,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   exp_start,
  output logic [WIDTH-1:0]       exp_x,
  input  logic [WIDTH-1:0]       exp_y,
  input  logic                   exp_done
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN,
    FLUSH
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  idx;
  logic [TMR_W-1:0]  timer;
  logic              flush_seen_done;

  logic              grant_found;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W-1:0]  cand;
  logic [IDX_W-1:0]  next_ptr;
  logic [N_REQ-1:0]  grant_onehot;
  logic [N_REQ-1:0]  idx_onehot;
  logic              timer_at_limit;
  int                pos;

  // Pick the first active request at or after rr_ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    pos         = 0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= N_REQ) begin
        pos = pos - N_REQ;
      end
      cand = IDX_W'(pos);
      if (!grant_found && req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Pointer advance, one-hot decodes and the shared timer limit.
  always_comb begin
    next_ptr       = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    grant_onehot   = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx;
    idx_onehot     = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    timer_at_limit = (timer == TMR_W'(TIMEOUT - 1));
  end

  // Job sequencing FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      idx             <= '0;
      timer           <= '0;
      flush_seen_done <= 1'b0;
      req_ack         <= '0;
      rsp_valid       <= '0;
      rsp_y           <= '0;
      rsp_err         <= 1'b0;
      busy            <= 1'b0;
      exp_start       <= 1'b0;
      exp_x           <= '0;
    end else begin
      req_ack   <= '0;
      rsp_valid <= '0;
      exp_start <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            exp_x   <= req_x[grant_idx*WIDTH +: WIDTH];
            idx     <= grant_idx;
            req_ack <= grant_onehot;
            rr_ptr  <= next_ptr;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          exp_start <= 1'b1;
          timer     <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          timer <= timer + TMR_W'(1);
          if (exp_done) begin
            rsp_y     <= exp_y;
            rsp_err   <= 1'b0;
            rsp_valid <= idx_onehot;
            state     <= DRAIN;
          end else if (timer_at_limit) begin
            rsp_y           <= '0;
            rsp_err         <= 1'b1;
            rsp_valid       <= idx_onehot;
            timer           <= '0;
            flush_seen_done <= 1'b0;
            state           <= FLUSH;
          end
        end
        DRAIN: begin
          // Wait out the second done cycle so it is never taken for a new job.
          if (!exp_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        FLUSH: begin
          if ((flush_seen_done && !exp_done) || timer_at_limit) begin
            timer <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
            if (exp_done) begin
              flush_seen_done <= 1'b1;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exp_arbiter.sv
// tb_exp_arbiter: table-driven check of exp_arbiter with a behavioural
// exponential unit (e^-x in Q16.16) that can be switched to a silent stub.
module tb_exp_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int T   = 12;
  localparam int LAT = 3;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_x;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_y;
  logic           rsp_err;
  logic           busy;
  logic           exp_start;
  logic [W-1:0]   exp_x;
  logic [W-1:0]   exp_y;
  logic           exp_done;

  logic           stub_mode;
  int             mdl_cnt;
  logic [W-1:0]   mdl_x;
  logic           mdl_second;

  int vectors;
  int miscompares;

  typedef struct {
    logic         stub;
    logic [3:0]   mask;
    logic [31:0]  x;
    logic [3:0]   exp_ack;
    logic [31:0]  exp_y;
    logic         exp_err;
    int           tol;
  } vec_t;

  vec_t vecs[6];

  logic [3:0]  got_ack;
  logic [3:0]  got_valid;
  logic [31:0] got_y;
  logic        got_err;
  int          starts;
  int          ack_cyc;
  int          start_cyc;
  int          rsp_cyc;
  int          idle_cyc;

  exp_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(T)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_x     (req_x),
    .req_ack   (req_ack),
    .rsp_valid (rsp_valid),
    .rsp_y     (rsp_y),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .exp_start (exp_start),
    .exp_x     (exp_x),
    .exp_y     (exp_y),
    .exp_done  (exp_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_model(input logic [31:0] x);
    real r;
    r = $exp(-($itor($signed(x)) / 65536.0));
    return 32'($rtoi(r * 65536.0 + 0.5));
  endfunction

  // Exponential unit: result LAT cycles after start, done held two cycles.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mdl_cnt    <= 0;
      mdl_x      <= '0;
      mdl_second <= 1'b0;
      exp_done   <= 1'b0;
      exp_y      <= '0;
    end else begin
      if (exp_start && !stub_mode) begin
        mdl_cnt <= LAT;
        mdl_x   <= exp_x;
      end else if (mdl_cnt != 0) begin
        mdl_cnt <= mdl_cnt - 1;
        if (mdl_cnt == 1) begin
          exp_done   <= 1'b1;
          exp_y      <= exp_model(mdl_x);
          mdl_second <= 1'b1;
        end
      end
      if (exp_done) begin
        if (mdl_second) mdl_second <= 1'b0;
        else            exp_done   <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv, input int tol);
    longint d;
    vectors++;
    d = longint'($signed(act)) - longint'($signed(expv));
    if (d < 0) d = -d;
    if (d > longint'(tol)) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (tol %0d)", name, act, expv, tol);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Run one job from a single-bit request and capture everything it produced.
  task automatic applyStimulus(input logic stub, input logic [3:0] mask, input logic [31:0] x);
    stub_mode = stub;
    req_x = '0;
    for (int i = 0; i < N; i++) if (mask[i]) req_x[i*W +: W] = x;
    req = mask;
    got_ack = '0; got_valid = '0; got_y = '0; got_err = 1'b0;
    starts = 0; ack_cyc = -100; start_cyc = -100; rsp_cyc = -100; idle_cyc = -100;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (req_ack != 0) begin
        got_ack = req_ack;
        ack_cyc = c;
        req = '0;
      end
      if (exp_start) begin
        starts++;
        start_cyc = c;
      end
      if (rsp_valid != 0) begin
        got_valid = rsp_valid;
        got_y = rsp_y;
        got_err = rsp_err;
        rsp_cyc = c;
      end
      if (got_valid != 0 && !busy) begin
        idle_cyc = c;
        break;
      end
    end
    req = '0;
  endtask

  // Hold several requests and check grant order and per-job responses.
  task automatic holdAndServe(input logic [3:0] mask, input int n_jobs, input logic [7:0] order);
    int acks;
    int rsps;
    int nst;
    int last;
    logic fin;
    acks = 0; rsps = 0; nst = 0; last = -1; fin = 1'b0;
    stub_mode = 1'b0;
    req = mask;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      if (exp_start) nst++;
      for (int i = 0; i < N; i++) begin
        if (req_ack[i]) begin
          last = i;
          req[i] = 1'b0;
          if (acks < 4) checkOutput("ack_order", 32'(i), 32'(order[2*acks +: 2]), 0);
          acks++;
        end
      end
      if (rsp_valid != 0 && last >= 0) begin
        rsps++;
        checkOutput("multi_valid", 32'(rsp_valid), 32'(4'b0001 << last), 0);
        checkOutput("multi_y", rsp_y, exp_model(req_x[last*W +: W]), 16);
      end
      if (rsps == n_jobs && !busy) fin = 1'b1;
    end
    req = '0;
    checkOutput("multi_jobs", 32'(rsps), 32'(n_jobs), 0);
    checkOutput("multi_starts", 32'(nst), 32'(n_jobs), 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0, 0);
    checkOutput({tag, "_ack"}, 32'(req_ack), 32'd0, 0);
    checkOutput({tag, "_valid"}, 32'(rsp_valid), 32'd0, 0);
    checkOutput({tag, "_y"}, rsp_y, 32'd0, 0);
    checkOutput({tag, "_err"}, 32'(rsp_err), 32'd0, 0);
    checkOutput({tag, "_start"}, 32'(exp_start), 32'd0, 0);
    checkOutput({tag, "_x"}, exp_x, 32'd0, 0);
  endtask

  initial begin
    int seen_valid;
    vectors = 0;
    miscompares = 0;
    req = '0;
    req_x = '0;
    stub_mode = 1'b0;
    reset = 1'b0;

    vecs[0] = '{1'b0, 4'b0001, 32'h0000_0000, 4'b0001, 32'h0001_0000, 1'b0, 16};
    vecs[1] = '{1'b0, 4'b0100, 32'h0001_0000, 4'b0100, 32'h0000_5E2D, 1'b0, 16};
    vecs[2] = '{1'b0, 4'b1000, 32'h0000_8000, 4'b1000, 32'h0000_9B46, 1'b0, 16};
    vecs[3] = '{1'b0, 4'b0010, 32'h0002_0000, 4'b0010, 32'h0000_22A5, 1'b0, 16};
    vecs[4] = '{1'b1, 4'b0010, 32'h0001_0000, 4'b0010, 32'h0000_0000, 1'b1, 0};
    vecs[5] = '{1'b0, 4'b0001, 32'hFFFF_0000, 4'b0001, 32'h0002_B7E1, 1'b0, 16};

    #1 reset = 1'b1;
    #2 checkAllZero("reset");
    doReset();

    // Single-requester jobs from the table.
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].stub, vecs[v].mask, vecs[v].x);
      checkOutput($sformatf("v%0d_ack", v), 32'(got_ack), 32'(vecs[v].exp_ack), 0);
      checkOutput($sformatf("v%0d_valid", v), 32'(got_valid), 32'(vecs[v].exp_ack), 0);
      checkOutput($sformatf("v%0d_y", v), got_y, vecs[v].exp_y, vecs[v].tol);
      checkOutput($sformatf("v%0d_err", v), 32'(got_err), 32'(vecs[v].exp_err), 0);
      checkOutput($sformatf("v%0d_starts", v), 32'(starts), 32'd1, 0);
      checkOutput($sformatf("v%0d_ack2start", v), 32'(start_cyc - ack_cyc), 32'd1, 0);
      if (vecs[v].stub) begin
        checkOutput($sformatf("v%0d_tmo_lat", v), 32'(rsp_cyc - start_cyc), 32'(T), 0);
        checkOutput($sformatf("v%0d_flush_lat", v), 32'(idle_cyc - rsp_cyc), 32'(T), 0);
      end
      @(negedge clk);
      checkOutput($sformatf("v%0d_hold", v), rsp_y, vecs[v].exp_y, vecs[v].tol);
    end

    // All four requesters held from reset release: served 0,1,2,3.
    reset = 1'b1;
    @(negedge clk);
    req_x = {32'h0002_0000, 32'h0001_0000, 32'h0000_8000, 32'h0000_0000};
    reset = 1'b0;
    holdAndServe(4'b1111, 4, 8'b11_10_01_00);

    // Move rr_ptr to 2 with a grant on requester 1, then wrap to 0 then 1.
    applyStimulus(1'b0, 4'b0010, 32'h0000_4000);
    checkOutput("pre_wrap_ack", 32'(got_ack), 32'b0010, 0);
    req_x = {32'h0, 32'h0, 32'h0003_0000, 32'h0000_C000};
    holdAndServe(4'b0011, 2, 8'b00_00_01_00);

    // Reset during WAIT abandons the job, then requester 3 runs normally.
    stub_mode = 1'b1;
    req_x = '0;
    req_x[0 +: W] = 32'h0001_0000;
    req = 4'b0001;
    seen_valid = 0;
    for (int c = 0; c < 20 && req != 0; c++) begin
      @(negedge clk);
      if (req_ack != 0) req = '0;
    end
    for (int c = 0; c < 20 && !exp_start; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 checkAllZero("midjob_reset");
    @(negedge clk);
    reset = 1'b0;
    stub_mode = 1'b0;
    for (int c = 0; c < 2 * T; c++) begin
      @(negedge clk);
      if (rsp_valid != 0) seen_valid++;
    end
    checkOutput("abandoned_valid", 32'(seen_valid), 32'd0, 0);
    applyStimulus(1'b0, 4'b1000, 32'h0001_0000);
    checkOutput("post_reset_ack", 32'(got_ack), 32'b1000, 0);
    checkOutput("post_reset_valid", 32'(got_valid), 32'b1000, 0);
    checkOutput("post_reset_y", got_y, 32'h0000_5E2D, 16);
    checkOutput("post_reset_err", 32'(got_err), 32'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exp_arbiter.md
EXP_ARBITER -- requirements
Module: exp_arbiter

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters sharing one exponential unit (2..8).
REQ-002 Parameter: WIDTH, default 32, Q16.16 operand/result width.
REQ-003 Parameter: TIMEOUT, default 32, max cycles from exp_start to exp_done before error.
REQ-004 Reset reset, asynchronous, active-high; clock clk.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 req  input  N_REQ  per-requester request level, held until acked.
REQ-008 req_x  input  N_REQ*WIDTH  per-requester signed Q16.16 operand; slice i = bits [i*WIDTH +: WIDTH].
REQ-009 req_ack  output  N_REQ  one-hot, one-cycle pulse: operand of requester i accepted.
REQ-010 rsp_valid  output  N_REQ  one-hot, one-cycle pulse: rsp_y/rsp_err valid for requester i.
REQ-011 rsp_y  output  WIDTH  signed Q16.16 result e^(-x).
REQ-012 rsp_err  output  1  qualifies rsp_valid; 1 = timeout, rsp_y = 0.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 exp_start  output  1  start to shared exponential unit.
REQ-015 exp_x  output  WIDTH  operand to exponential unit.
REQ-016 exp_y  input  WIDTH  result from exponential unit.
REQ-017 exp_done  input  1  done from exponential unit (high two cycles per job).

Function
REQ-018 States SHALL be IDLE, ISSUE, WAIT, DRAIN, FLUSH; all outputs registered.
REQ-019 IDLE: if any req bit set, grant lowest index >= rr_ptr (wrapping), latch req_x slice into exp_x, store index, pulse req_ack[idx], go ISSUE.
REQ-020 rr_ptr SHALL update to (idx+1) mod N_REQ on each grant; reset value 0.
REQ-021 Requests dropped before ack SHALL be ignored; req_x sampled only in the grant cycle.
REQ-022 ISSUE: exp_start=1 for exactly one cycle, timer cleared, go WAIT; exp_x SHALL stay constant from grant until next grant.
REQ-023 WAIT: exp_start=0; timer increments each cycle; first cycle with exp_done=1: rsp_y<=exp_y, rsp_err<=0, pulse rsp_valid[idx], go DRAIN.
REQ-024 WAIT: if timer reaches TIMEOUT with exp_done=0: rsp_y<=0, rsp_err<=1, pulse rsp_valid[idx], timer cleared, go FLUSH.
REQ-025 DRAIN: stay until exp_done=0, then go IDLE (guarantees exp_start low >= 1 cycle and done not reused).
REQ-026 FLUSH: discard exp_y; go IDLE after exp_done observed high then low, or after TIMEOUT further cycles, whichever first.
REQ-027 rsp_y and rsp_err SHALL hold their values until the next rsp_valid pulse.
REQ-028 Minimum request-to-response latency: ack at grant cycle, exp_start next cycle, rsp_valid the cycle after exp_done first seen high.
REQ-029 At most one job outstanding; no new grant until IDLE is re-entered.
REQ-030 req bits for a requester already granted but still asserted SHALL be treated as a new request in IDLE.
REQ-031 exp_done high while in IDLE or ISSUE SHALL be ignored.

Reset
REQ-032 On reset assertion, immediately: state=IDLE, rr_ptr=0, req_ack=0, rsp_valid=0, rsp_y=0, rsp_err=0, busy=0, exp_start=0, exp_x=0, timer=0.
REQ-033 Reset mid-job SHALL abandon the job with no rsp_valid; the exponential unit shares the same reset.

Verification
REQ-034 Single req[0], x=0x00000000, real exponential unit -> req_ack=0001, one exp_start pulse, rsp_valid=0001, rsp_y=0x00010000, rsp_err=0.
REQ-035 req[2], x=0x00010000 -> rsp_valid=0100, rsp_y within +/-0x10 of 0x00005E2D, rsp_err=0.
REQ-036 req=1111 held from reset release, distinct x each -> acks in order 0,1,2,3; each rsp_valid matches its ack index and its own x; exactly one exp_start per job.
REQ-037 rr_ptr=2 with req=0011 -> grant 0 first, then 1 (wrap-around).
REQ-038 Stub exponential never asserting exp_done, req[1] -> rsp_valid=0010, rsp_err=1, rsp_y=0 exactly TIMEOUT cycles after WAIT entry; IDLE reached TIMEOUT cycles later.
REQ-039 Reset asserted during WAIT -> all outputs zero same cycle; after release, new req[3] completes normally with correct result.
